// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants, direction encodings and car state type
// Contents: NUM_FLOORS / FLOOR_W floor geometry, DIR_UP / DIR_DOWN direction
// encodings, car_state_t sequencer state enumeration.
package elevator_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W    = $clog2(NUM_FLOORS);

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    DEPART,
    MOVING,
    CLEAR,
    DOOR_OPEN
  } car_state_t;

endpackage

// File: rtl/elevator_cycle_timer.sv
// rtl/elevator_cycle_timer.sv - loadable down-counter that stops at zero
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load strobe, takes priority over counting
//   load_value  value loaded on load
//   done        high while the count is zero
module elevator_cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// rtl/elevator_car_controller.sv - car motion and door sequencer
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   queue_status      pending-request bitmap, bit i = request at floor i
//   queue_empty       high when queue_status is all zero
//   next_up_ndown     resolver direction decision, 1 = up
//   current_floor     registered car position
//   current_up_ndown  registered committed direction
//   moving            high while travelling between floors
//   door_open         high while the door dwells open
//   clear_valid       request-clear strobe towards the queue
//   clear_floor       floor being cleared, stable while clear_valid
//   clear_ready       queue accepts the clear
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W       = elevator_pkg::FLOOR_W,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] queue_status,
  input  logic                  queue_empty,
  input  logic                  next_up_ndown,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  current_up_ndown,
  output logic                  moving,
  output logic                  door_open,
  output logic                  clear_valid,
  output logic [FLOOR_W-1:0]    clear_floor,
  input  logic                  clear_ready
);

  // One timer serves both travel and door dwell; it must hold the larger
  // reload value (period - 1).
  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  car_state_t         state;
  logic               blocked;
  logic [FLOOR_W-1:0] step_floor;
  logic               timer_load;
  logic [TW-1:0]      timer_value;
  logic               timer_done;

  // Resolver asks to leave through the roof or the floor: refuse the move.
  assign blocked = (next_up_ndown == DIR_UP) ? (current_floor == TOP_FLOOR)
                                             : (current_floor == '0);

  // Floor the car reaches when the current travel step completes.
  assign step_floor = (current_up_ndown == DIR_UP) ? current_floor + FLOOR_W'(1)
                                                   : current_floor - FLOOR_W'(1);

  // Reload on entry to MOVING (travel) or DOOR_OPEN (dwell).
  assign timer_load  = ((state == DEPART) && !blocked) ||
                       ((state == CLEAR) && clear_ready);
  assign timer_value = (state == DEPART) ? TRAVEL_LOAD : DOOR_LOAD;

  elevator_cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      current_floor    <= '0;
      current_up_ndown <= DIR_UP;
      moving           <= 1'b0;
      door_open        <= 1'b0;
      clear_valid      <= 1'b0;
      clear_floor      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (queue_status[current_floor]) begin
            state       <= CLEAR;
            clear_valid <= 1'b1;
            clear_floor <= current_floor;
          end else if (!queue_empty) begin
            state <= DEPART;
          end
        end

        DEPART: begin
          if (blocked) begin
            // Flip so the resolver sees a direction it can actually serve.
            current_up_ndown <= ~next_up_ndown;
            state            <= IDLE;
          end else begin
            current_up_ndown <= next_up_ndown;
            moving           <= 1'b1;
            state            <= MOVING;
          end
        end

        MOVING: begin
          if (timer_done) begin
            current_floor <= step_floor;
            moving        <= 1'b0;
            if (queue_status[step_floor]) begin
              state       <= CLEAR;
              clear_valid <= 1'b1;
              clear_floor <= step_floor;
            end else if (queue_empty) begin
              state <= IDLE;
            end else begin
              // Stop for one DEPART cycle so direction is re-sampled per floor.
              state <= DEPART;
            end
          end
        end

        CLEAR: begin
          if (clear_ready) begin
            clear_valid <= 1'b0;
            door_open   <= 1'b1;
            state       <= DOOR_OPEN;
          end
        end

        DOOR_OPEN: begin
          if (timer_done) begin
            if (queue_status[current_floor]) begin
              // Re-request during dwell: keep the door open through CLEAR.
              state       <= CLEAR;
              clear_valid <= 1'b1;
              clear_floor <= current_floor;
            end else begin
              door_open <= 1'b0;
              state     <= queue_empty ? IDLE : DEPART;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
